hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Time-multiplexed scan controller that shares one hex-to-7-segment decode path across eight common-anode digits. It captures a 32-bit display word from the datapath (PC, ALU result, memory data) through a valid/ready handshake, then cycles digit enables and segment patterns nibble by nibble. New words are accepted only at frame boundaries, so a frame never mixes old and new data. It sits between the processor's debug/display mux and the board's shared segment/anode pins.

## Interface
- DWELL, 50000: cycles each digit stays lit; minimum 1.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  32  word to display; nibble k goes to digit k (digit 0 = bits 3:0).
- load_ready  output  1  controller accepts load_data this cycle.
- disp_en  input  1  0 forces all digits off; scanning continues.
- an  output  8  digit enables, active-low, one-hot-low while scanning.
- seg  output  7  segments gfedcba, active-low.

## Operation
- Handshake: a transfer occurs on an edge where load_valid and load_ready are both 1. load_data is captured into a 32-bit snapshot. The producer holds load_valid and load_data until the transfer.
- FSM states:
  - IDLE: load_ready=1; an=8'hFF, seg=7'h7F. On transfer: snapshot<=load_data, idx<=0, cnt<=0, go to SCAN.
  - SCAN: cnt counts 0..DWELL-1. At DWELL-1, cnt wraps to 0 and idx increments modulo 8.
    - load_ready=1 only when idx==7 and cnt==DWELL-1 (last frame cycle).
    - A transfer in that cycle replaces the snapshot for the next frame.
    - With no transfer, the next frame redisplays the old snapshot.
    - SCAN never returns to IDLE except by reset.
- Decode, nibble to seg (hex of 7-bit gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E.
- Output registers:
  - an <= ~(1<<idx_next), seg <= decode(nibble idx_next), where idx_next is the idx value for the coming cycle.
  - On the transfer edge out of IDLE, the digit 0 pattern is computed from load_data directly.
  - disp_en=0: an<=8'hFF; seg still updates.
- Counter width: $clog2(DWELL), minimum 1 bit. DWELL=1 changes digit every cycle.
- Reset values: state IDLE, snapshot 0, idx 0, cnt 0, an=8'hFF, seg=7'h7F, load_ready=1.

## Timing
- Transfer at edge E: from E through E+DWELL-1, an=8'hFE and seg=decode(load_data[3:0]). Digit k is lit during edges E+k*DWELL .. E+(k+1)*DWELL-1.
- Frame length: exactly 8*DWELL cycles. No gap cycles between digits or frames.
- Back-to-back transfers are possible only once per frame. A new word first appears on digit 0 at the edge after the last-frame-cycle transfer.
- an and seg always change on the same edge, so no ghosting cycle exists.
- rst_n sampled low at any edge, including mid-frame or during a transfer: all state takes reset values at that edge. No transfer is recorded.
- disp_en is effective one cycle after it changes (registered). Re-enable resumes at the current idx.

## Configuration
- HEX_BLANK_EN defined: leading-zero blanking.
  - For digits k>m, the an bit is forced to 1, where m is the index of the most-significant nonzero nibble of the snapshot.
  - Digit 0 is never blanked; a snapshot of 0 shows "0" on digit 0 only.
  - Timing and frame length are unchanged.
- HEX_BLANK_EN undefined: all eight digits are driven; leading zeros are shown as 7'h40.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> an=8'hFF, seg=7'h7F, load_ready=1.
- DWELL=4, load 32'h0000_00A5 in IDLE, macro undefined:
  - 4 cycles an=FE, seg=12;
  - then 4 cycles an=FD, seg=08;
  - then digits 2..7 with seg=40, ending an=7F;
  - frame repeats after 32 cycles.
- Mid-frame load of 32'h1234_5678 (valid raised at idx 2):
  - load_ready stays 0 until idx=7, cnt=3; exactly one transfer;
  - the next edge gives an=FE, seg=00 ('8').
- HEX_BLANK_EN defined, word 32'h0000_00A5 -> an bits 7..2 stay 1 all frame; digits 0 and 1 are lit as above. Word 0 -> only an[0] goes low, seg=40.
- rst_n=0 at idx 3 mid-frame -> next edge an=FF, seg=7F, IDLE; with no new load, display stays dark.
- disp_en=0 for 10 cycles during SCAN -> an=FF from the following edge; idx/cnt keep advancing; re-enable shows the digit matching the current idx.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed 8-digit hex scanner for common-anode 7-seg displays.
// an/seg registered, updated together each cycle; load_ready only in IDLE or on the last frame cycle.
// Optional HEX_BLANK_EN: blank digits above the most-significant nonzero nibble.
module hex_scan_ctrl #(
    parameter int DWELL = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        disp_en,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state, state_n;
    logic [31:0]   snap, snap_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    an_n;
    logic [6:0]    seg_n;
    logic [3:0]    nib;
    logic          blank;
    logic          xfer;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef HEX_BLANK_EN
    // Index of the highest nonzero nibble; 0 for an all-zero word so digit 0 stays lit.
    function automatic logic [2:0] top_nz(input logic [31:0] w);
        logic [2:0] m;
        m = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (w[4*k +: 4] != 4'h0) m = 3'(k);
        end
        return m;
    endfunction
`endif

    always_comb begin
        state_n    = state;
        snap_n     = snap;
        idx_n      = idx;
        cnt_n      = cnt;
        an_n       = 8'hFF;
        seg_n      = 7'h7F;
        nib        = 4'h0;
        blank      = 1'b0;
        load_ready = (state == IDLE) || ((idx == 3'd7) && (cnt == CNT_LAST));
        xfer       = load_valid && load_ready;

        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = SCAN;
                    snap_n  = load_data;
                    idx_n   = 3'd0;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    idx_n = idx + 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
                if (xfer) snap_n = load_data;
            end
        endcase

        // Outputs are computed from next-cycle state so an and seg switch on the same edge.
        if (state_n == SCAN) begin
            nib   = snap_n[{idx_n, 2'b00} +: 4];
            seg_n = decode(nib);
            an_n  = ~(8'b1 << idx_n);
`ifdef HEX_BLANK_EN
            blank = (idx_n > top_nz(snap_n));
`endif
            if (!disp_en || blank) an_n = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            snap  <= 32'h0;
            idx   <= 3'd0;
            cnt   <= '0;
            an    <= 8'hFF;
            seg   <= 7'h7F;
        end else begin
            state <= state_n;
            snap  <= snap_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            an    <= an_n;
            seg   <= seg_n;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl with DWELL=4: vector table for the first frame plus directed sequences.
module tb_hex_scan_ctrl;

    localparam int DW = 4;
`ifdef HEX_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        disp_en;
    logic [7:0]  an;
    logic [6:0]  seg;

    hex_scan_ctrl #(.DWELL(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .disp_en   (disp_en),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        rdy;
    } vec_t;

    vec_t        vt[33];
    logic [6:0]  seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0]  an_dig[8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0]  seg_a5[8]  = '{7'h12, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    int          checks = 0;
    int          errors = 0;
    int          pos;
    logic [31:0] cur_word;
    logic        en_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        en_q = disp_en;
        @(posedge clk);
        #1;
        pos++;
    endtask

    function automatic logic [7:0] exp_an(input logic [31:0] w, input int d, input logic en);
        int m;
        m = 0;
        for (int k = 0; k < 8; k++) if (((w >> (4 * k)) & 32'hF) != 0) m = k;
        if (!en) return 8'hFF;
        if (BLANK && d > m) return 8'hFF;
        return ~(8'b1 << d);
    endfunction

    // Advance one cycle and compare against the frame-position model.
    task automatic step(input string nm);
        int d;
        tick();
        d = (pos / DW) % 8;
        chk({nm, "_an"}, {24'h0, an}, {24'h0, exp_an(cur_word, d, en_q)});
        chk({nm, "_seg"}, {25'h0, seg}, {25'h0, seg_tab[(cur_word >> (4 * d)) & 32'hF]});
        chk({nm, "_rdy"}, {31'h0, load_ready}, {31'h0, (pos % (8 * DW)) == (8 * DW - 1)});
    endtask

    initial begin
        int  waits;
        bit  got;

        for (int j = 0; j < 32; j++) begin
            vt[j].vld = (j == 0);
            vt[j].dat = 32'h0000_00A5;
            vt[j].an  = (BLANK && (j / DW) >= 2) ? 8'hFF : an_dig[j / DW];
            vt[j].seg = seg_a5[j / DW];
            vt[j].rdy = (j == 31);
        end
        vt[32] = '{1'b0, 32'h0000_00A5, 8'hFE, 7'h12, 1'b0};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        disp_en    = 1'b1;
        pos        = 0;
        cur_word   = 32'h0;
        repeat (2) tick();
        chk("reset_an", {24'h0, an}, 32'hFF);
        chk("reset_seg", {25'h0, seg}, 32'h7F);
        chk("reset_rdy", {31'h0, load_ready}, 32'h1);

        rst_n = 1'b1;
        tick();
        chk("idle_an", {24'h0, an}, 32'hFF);
        chk("idle_rdy", {31'h0, load_ready}, 32'h1);

        for (int i = 0; i < 33; i++) begin
            load_valid = vt[i].vld;
            load_data  = vt[i].dat;
            tick();
            chk($sformatf("vec%0d_an", i), {24'h0, an}, {24'h0, vt[i].an});
            chk($sformatf("vec%0d_seg", i), {25'h0, seg}, {25'h0, vt[i].seg});
            chk($sformatf("vec%0d_rdy", i), {31'h0, load_ready}, {31'h0, vt[i].rdy});
        end
        load_valid = 1'b0;
        cur_word   = 32'h0000_00A5;
        pos        = 32;

        repeat (8) step("pre_mid");

        // Mid-frame request must wait for the last frame cycle.
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        waits      = 0;
        got        = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (load_ready) begin
                got = 1'b1;
                tick();
                load_valid = 1'b0;
                cur_word   = 32'h1234_5678;
                pos        = 0;
                chk("mid_xfer_an", {24'h0, an}, 32'hFE);
                chk("mid_xfer_seg", {25'h0, seg}, 32'h00);
            end else begin
                waits++;
                step("mid_wait");
            end
        end
        chk("mid_got_xfer", {31'h0, got}, 32'h1);
        chk("mid_wait_cycles", waits, 23);
        load_valid = 1'b0;

        repeat (7) step("word2");
        chk("word2_digit1_seg", {25'h0, seg}, 32'h78);

        disp_en = 1'b0;
        repeat (10) step("dis");
        disp_en = 1'b1;
        repeat (3) step("reen");

        while (((pos / DW) % 8) != 3 && pos < 1000) step("to_idx3");
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hFFFF_FFFF;
        tick();
        chk("midrst_an", {24'h0, an}, 32'hFF);
        chk("midrst_seg", {25'h0, seg}, 32'h7F);
        chk("midrst_rdy", {31'h0, load_ready}, 32'h1);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("dark%0d_an", c), {24'h0, an}, 32'hFF);
            chk($sformatf("dark%0d_seg", c), {25'h0, seg}, 32'h7F);
        end

        // Zero word: digit 0 shows "0"; other digits depend on blanking.
        load_valid = 1'b1;
        load_data  = 32'h0;
        tick();
        load_valid = 1'b0;
        cur_word   = 32'h0;
        pos        = 0;
        chk("zero_d0_an", {24'h0, an}, 32'hFE);
        chk("zero_d0_seg", {25'h0, seg}, 32'h40);
        repeat (31) step("zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
